// File: rtl/ram_read_sequencer.sv
// Walks the RAM read port over a latched [first, last) window, one word per clock,
// and forwards each returned word with a write strobe and a 0-based buffer index.
module ram_read_sequencer #(
    parameter int SIZE   = 24,
    parameter int AW     = 13,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      step,
    input  logic            re_RAM,
    input  logic [AW-1:0]   firstaddr,
    input  logic [AW-1:0]   lastaddr,
    input  logic [SIZE-1:0] ram_q,
    output logic [AW-1:0]   ram_addr,
    output logic            ram_re,
    output logic            wr_en,
    output logic [AW-1:0]   wr_index,
    output logic [SIZE-1:0] dout,
    output logic            busy,
    output logic            done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [AW-1:0] ONE = AW'(1);

    logic [1:0]        state_q, state_d;
    logic [AW-1:0]     first_q, first_d;
    logic [AW-1:0]     last_q, last_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [4:0]        step_q, step_d;
    logic [4:0]        step_done_q, step_done_d;
    logic [RD_LAT-1:0] pv_q, pv_d;
    logic [AW-1:0]     pidx_q [RD_LAT];
    logic [AW-1:0]     pidx_d [RD_LAT];

    logic              issue;
    logic              flush;
    logic [RD_LAT-1:0] pv_shift;

    assign issue = (state_q == S_READ);

    // Latency pipe: valid bit and index travel alongside each read.
    always_comb begin
        pv_shift[0] = issue;
        pidx_d[0]   = addr_q - first_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pv_shift[i] = pv_q[i-1];
            pidx_d[i]   = pidx_q[i-1];
        end
        pv_d = flush ? '0 : pv_shift;
    end

    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        last_d      = last_q;
        addr_d      = addr_q;
        step_d      = step_q;
        step_done_d = step_done_q;
        flush       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (re_RAM && (step != step_done_q)) begin
                    first_d = firstaddr;
                    last_d  = lastaddr;
                    step_d  = step;
                    addr_d  = firstaddr;
                    state_d = (firstaddr >= lastaddr) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (!re_RAM) begin
                    state_d = S_IDLE;
                    flush   = 1'b1;
                end else if (addr_q == last_q - ONE) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + ONE;
                end
            end
            S_DRAIN: begin
                if (!re_RAM) begin
                    state_d = S_IDLE;
                    flush   = 1'b1;
                end else if (~|pv_shift) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                step_done_d = step_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            first_q     <= '0;
            last_q      <= '0;
            addr_q      <= '0;
            step_q      <= '0;
            step_done_q <= '0;
            pv_q        <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pidx_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            step_q      <= step_d;
            step_done_q <= step_done_d;
            pv_q        <= pv_d;
            for (int i = 0; i < RD_LAT; i++) begin
                pidx_q[i] <= pidx_d[i];
            end
        end
    end

    assign ram_re   = issue;
    assign ram_addr = addr_q;
    assign wr_en    = pv_q[RD_LAT-1];
    assign wr_index = pidx_q[RD_LAT-1];
    assign dout     = wr_en ? ram_q : '0;
    assign busy     = (state_q == S_READ) || (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_ram_read_sequencer.sv
// Directed bench: two sequencer instances (read latency 1 and 3) with
// behavioural RAMs; per-scenario tasks compare logged activity against hand values.
module tb_ram_read_sequencer;

    localparam int SIZE = 24;
    localparam int AW   = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs = 0;
    int checks = 0;

    function automatic logic [SIZE-1:0] f(input int a);
        logic [AW-1:0] aw;
        aw = AW'(a);
        return {11'h2B5, aw};
    endfunction

    // Instance A: RD_LAT=1
    logic [4:0]      a_step;
    logic            a_re;
    logic [AW-1:0]   a_first, a_last, a_addr, a_idx;
    logic [SIZE-1:0] a_q, a_dout;
    logic            a_ram_re, a_wr, a_busy, a_done;

    // Instance B: RD_LAT=3
    logic [4:0]      b_step;
    logic            b_re;
    logic [AW-1:0]   b_first, b_last, b_addr, b_idx;
    logic [SIZE-1:0] b_q, b_dout, b_p1, b_p2;
    logic            b_ram_re, b_wr, b_busy, b_done;

    ram_read_sequencer #(.SIZE(SIZE), .AW(AW), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .step(a_step), .re_RAM(a_re),
        .firstaddr(a_first), .lastaddr(a_last), .ram_q(a_q),
        .ram_addr(a_addr), .ram_re(a_ram_re), .wr_en(a_wr),
        .wr_index(a_idx), .dout(a_dout), .busy(a_busy), .done(a_done)
    );

    ram_read_sequencer #(.SIZE(SIZE), .AW(AW), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .step(b_step), .re_RAM(b_re),
        .firstaddr(b_first), .lastaddr(b_last), .ram_q(b_q),
        .ram_addr(b_addr), .ram_re(b_ram_re), .wr_en(b_wr),
        .wr_index(b_idx), .dout(b_dout), .busy(b_busy), .done(b_done)
    );

    always @(posedge clk) begin
        a_q  <= a_ram_re ? f(int'(a_addr)) : '0;
        b_p1 <= b_ram_re ? f(int'(b_addr)) : '0;
        b_p2 <= b_p1;
        b_q  <= b_p2;
    end

    int a_re_addr[$], a_re_cyc[$], a_wr_idx[$], a_wr_cyc[$], a_done_cyc[$];
    int b_re_addr[$], b_re_cyc[$], b_wr_idx[$], b_wr_cyc[$], b_done_cyc[$];
    logic [SIZE-1:0] a_wr_dat[$], b_wr_dat[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (a_ram_re) begin
                a_re_addr.push_back(int'(a_addr));
                a_re_cyc.push_back(cyc);
            end
            if (a_wr) begin
                a_wr_idx.push_back(int'(a_idx));
                a_wr_dat.push_back(a_dout);
                a_wr_cyc.push_back(cyc);
            end
            if (a_done) a_done_cyc.push_back(cyc);
            if (b_ram_re) begin
                b_re_addr.push_back(int'(b_addr));
                b_re_cyc.push_back(cyc);
            end
            if (b_wr) begin
                b_wr_idx.push_back(int'(b_idx));
                b_wr_dat.push_back(b_dout);
                b_wr_cyc.push_back(cyc);
            end
            if (b_done) b_done_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        a_re_addr.delete(); a_re_cyc.delete(); a_wr_idx.delete();
        a_wr_cyc.delete(); a_wr_dat.delete(); a_done_cyc.delete();
        b_re_addr.delete(); b_re_cyc.delete(); b_wr_idx.delete();
        b_wr_cyc.delete(); b_wr_dat.delete(); b_done_cyc.delete();
    endtask

    task automatic test_reset();
        tick(3);
        checks++;
        if ({a_addr, a_ram_re, a_wr, a_idx, a_dout, a_busy, a_done} !== '0) begin
            errs++;
            $display("FAIL reset_a: outputs not zero, addr=%0d re=%b wr=%b busy=%b done=%b",
                     a_addr, a_ram_re, a_wr, a_busy, a_done);
        end
        checks++;
        if ({b_addr, b_ram_re, b_wr, b_idx, b_dout, b_busy, b_done} !== '0) begin
            errs++;
            $display("FAIL reset_b: outputs not zero, addr=%0d re=%b wr=%b busy=%b done=%b",
                     b_addr, b_ram_re, b_wr, b_busy, b_done);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_reset_mid_read();
        int cs;
        a_step = 5'd1; a_first = 13'd0; a_last = 13'd16; a_re = 1'b1;
        tick(6);
        checks++;
        if (a_busy !== 1'b1) begin
            errs++;
            $display("FAIL midread_busy: got %b want 1", a_busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({a_addr, a_ram_re, a_wr, a_idx, a_dout, a_busy, a_done} !== '0) begin
            errs++;
            $display("FAIL midread_reset: outputs not zero, addr=%0d re=%b wr=%b busy=%b",
                     a_addr, a_ram_re, a_wr, a_busy);
        end
        tick(1);
        clear_logs();
        rst = 1'b0;
        cs = cyc;
        tick(25);
        checks++;
        if (a_re_addr.size() != 16) begin
            errs++;
            $display("FAIL load1_re_count: got %0d want 16", a_re_addr.size());
        end
        for (int i = 0; i < 16 && i < a_re_addr.size(); i++) begin
            checks++;
            if (a_re_addr[i] != i || a_re_cyc[i] != cs + 1 + i) begin
                errs++;
                $display("FAIL load1_re[%0d]: addr %0d cyc %0d want addr %0d cyc %0d",
                         i, a_re_addr[i], a_re_cyc[i], i, cs + 1 + i);
            end
        end
        checks++;
        if (a_wr_idx.size() != 16) begin
            errs++;
            $display("FAIL load1_wr_count: got %0d want 16", a_wr_idx.size());
        end
        for (int i = 0; i < 16 && i < a_wr_idx.size(); i++) begin
            checks++;
            if (a_wr_idx[i] != i || a_wr_dat[i] !== f(i) || a_wr_cyc[i] != cs + 2 + i) begin
                errs++;
                $display("FAIL load1_wr[%0d]: idx %0d dat %h cyc %0d want idx %0d dat %h cyc %0d",
                         i, a_wr_idx[i], a_wr_dat[i], a_wr_cyc[i], i, f(i), cs + 2 + i);
            end
        end
        checks++;
        if (a_done_cyc.size() != 1 || a_done_cyc[0] != cs + 18) begin
            errs++;
            $display("FAIL load1_done: count %0d first %0d want count 1 at %0d",
                     a_done_cyc.size(), a_done_cyc.size() > 0 ? a_done_cyc[0] : -1, cs + 18);
        end
    endtask

    task automatic test_hold_same_step();
        clear_logs();
        tick(8);
        checks++;
        if (a_re_addr.size() != 0 || a_wr_idx.size() != 0 || a_done_cyc.size() != 0) begin
            errs++;
            $display("FAIL hold_a: re %0d wr %0d done %0d want 0 0 0",
                     a_re_addr.size(), a_wr_idx.size(), a_done_cyc.size());
        end
    endtask

    task automatic test_empty();
        clear_logs();
        a_step = 5'd3; a_first = 13'd40; a_last = 13'd40;
        tick(6);
        checks++;
        if (a_re_addr.size() != 0 || a_wr_idx.size() != 0 || a_done_cyc.size() != 1) begin
            errs++;
            $display("FAIL empty: re %0d wr %0d done %0d want 0 0 1",
                     a_re_addr.size(), a_wr_idx.size(), a_done_cyc.size());
        end
    endtask

    task automatic test_abort();
        int n, ka, cs;
        clear_logs();
        a_step = 5'd5; a_first = 13'd0; a_last = 13'd16;
        n = 0;
        while (a_re_addr.size() < 5 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 50) begin
            errs++;
            $display("FAIL abort_wait: got %0d reads want 5", a_re_addr.size());
        end
        @(posedge clk);
        #1;
        a_re = 1'b0;
        ka = cyc;
        tick(6);
        checks++;
        if (a_re_addr.size() != 6 || a_re_addr[5] != 5 || a_re_cyc[5] != ka) begin
            errs++;
            $display("FAIL abort_re: count %0d want 6, last cyc %0d want %0d",
                     a_re_addr.size(), a_re_cyc[a_re_cyc.size()-1], ka);
        end
        checks++;
        if (a_wr_idx.size() != 5 || a_wr_idx[4] != 4) begin
            errs++;
            $display("FAIL abort_wr: count %0d want 5", a_wr_idx.size());
        end
        checks++;
        if (a_done_cyc.size() != 0 || a_busy !== 1'b0) begin
            errs++;
            $display("FAIL abort_done: done %0d busy %b want 0 0", a_done_cyc.size(), a_busy);
        end
        clear_logs();
        a_re = 1'b1;
        cs = cyc;
        tick(25);
        checks++;
        if (a_re_addr.size() != 16 || a_re_addr[0] != 0 || a_re_cyc[0] != cs + 1) begin
            errs++;
            $display("FAIL reload_re: count %0d want 16, start at 0 cyc %0d",
                     a_re_addr.size(), cs + 1);
        end
        checks++;
        if (a_wr_idx.size() != 16) begin
            errs++;
            $display("FAIL reload_wr_count: got %0d want 16", a_wr_idx.size());
        end
        for (int i = 0; i < 16 && i < a_wr_idx.size(); i++) begin
            checks++;
            if (a_wr_idx[i] != i || a_wr_dat[i] !== f(i)) begin
                errs++;
                $display("FAIL reload_wr[%0d]: idx %0d dat %h want %0d %h",
                         i, a_wr_idx[i], a_wr_dat[i], i, f(i));
            end
        end
        checks++;
        if (a_done_cyc.size() != 1 || a_done_cyc[0] != cs + 18) begin
            errs++;
            $display("FAIL reload_done: count %0d want 1 at %0d", a_done_cyc.size(), cs + 18);
        end
    endtask

    task automatic test_rdlat3();
        int cs;
        clear_logs();
        b_step = 5'd2; b_first = 13'd16; b_last = 13'd20; b_re = 1'b1;
        cs = cyc;
        tick(15);
        checks++;
        if (b_re_addr.size() != 4) begin
            errs++;
            $display("FAIL lat3_re_count: got %0d want 4", b_re_addr.size());
        end
        for (int i = 0; i < 4 && i < b_re_addr.size(); i++) begin
            checks++;
            if (b_re_addr[i] != 16 + i || b_re_cyc[i] != cs + 1 + i) begin
                errs++;
                $display("FAIL lat3_re[%0d]: addr %0d cyc %0d want %0d %0d",
                         i, b_re_addr[i], b_re_cyc[i], 16 + i, cs + 1 + i);
            end
        end
        checks++;
        if (b_wr_idx.size() != 4) begin
            errs++;
            $display("FAIL lat3_wr_count: got %0d want 4", b_wr_idx.size());
        end
        for (int i = 0; i < 4 && i < b_wr_idx.size(); i++) begin
            checks++;
            if (b_wr_idx[i] != i || b_wr_dat[i] !== f(16 + i) || b_wr_cyc[i] != cs + 4 + i) begin
                errs++;
                $display("FAIL lat3_wr[%0d]: idx %0d dat %h cyc %0d want %0d %h %0d",
                         i, b_wr_idx[i], b_wr_dat[i], b_wr_cyc[i], i, f(16 + i), cs + 4 + i);
            end
        end
        checks++;
        if (b_done_cyc.size() != 1 || b_done_cyc[0] != cs + 8) begin
            errs++;
            $display("FAIL lat3_done: count %0d want 1 at %0d", b_done_cyc.size(), cs + 8);
        end
    endtask

    task automatic test_back_to_back();
        int cs;
        clear_logs();
        tick(10);
        checks++;
        if (b_re_addr.size() != 0 || b_done_cyc.size() != 0) begin
            errs++;
            $display("FAIL b2b_hold: re %0d done %0d want 0 0", b_re_addr.size(), b_done_cyc.size());
        end
        b_step = 5'd4; b_first = 13'd20; b_last = 13'd36;
        cs = cyc;
        tick(3);
        b_step = 5'd6; b_first = 13'd8; b_last = 13'd10;
        tick(35);
        checks++;
        if (b_re_addr.size() != 18) begin
            errs++;
            $display("FAIL b2b_re_count: got %0d want 18", b_re_addr.size());
        end
        for (int i = 0; i < 16 && i < b_re_addr.size(); i++) begin
            checks++;
            if (b_re_addr[i] != 20 + i || b_re_cyc[i] != cs + 1 + i) begin
                errs++;
                $display("FAIL b2b_re[%0d]: addr %0d cyc %0d want %0d %0d",
                         i, b_re_addr[i], b_re_cyc[i], 20 + i, cs + 1 + i);
            end
        end
        checks++;
        if (b_re_addr.size() == 18 &&
            (b_re_addr[16] != 8 || b_re_addr[17] != 9 || b_re_cyc[16] != cs + 22)) begin
            errs++;
            $display("FAIL b2b_next_re: addr %0d,%0d cyc %0d want 8,9 cyc %0d",
                     b_re_addr[16], b_re_addr[17], b_re_cyc[16], cs + 22);
        end
        checks++;
        if (b_wr_idx.size() != 18) begin
            errs++;
            $display("FAIL b2b_wr_count: got %0d want 18", b_wr_idx.size());
        end
        for (int i = 0; i < 18 && i < b_wr_idx.size(); i++) begin
            checks++;
            if (b_wr_idx[i] != (i < 16 ? i : i - 16) ||
                b_wr_dat[i] !== f(i < 16 ? 20 + i : i - 8)) begin
                errs++;
                $display("FAIL b2b_wr[%0d]: idx %0d dat %h want %0d %h", i, b_wr_idx[i],
                         b_wr_dat[i], i < 16 ? i : i - 16, f(i < 16 ? 20 + i : i - 8));
            end
        end
        checks++;
        if (b_done_cyc.size() != 2 || b_done_cyc[0] != cs + 20 || b_done_cyc[1] != cs + 27) begin
            errs++;
            $display("FAIL b2b_done: count %0d want 2 at %0d,%0d",
                     b_done_cyc.size(), cs + 20, cs + 27);
        end
    endtask

    initial begin
        a_step = '0; a_re = 1'b0; a_first = '0; a_last = '0;
        b_step = '0; b_re = 1'b0; b_first = '0; b_last = '0;
        test_reset();
        test_reset_mid_read();
        test_hold_same_step();
        test_empty();
        test_abort();
        test_rdlat3();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
